// File: rtl/tt_um_seq_divider.sv
// 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIVZERO_DETECT_EN: a zero divisor finishes in one edge and raises err.
module tt_um_seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] dvd, dvd_nx;
  logic [3:0] dvs, dvs_nx;
  logic [3:0] rem, rem_nx;
  logic [3:0] quo, quo_nx;
  logic [3:0] q, q_nx;
  logic [3:0] r, r_nx;
  logic [1:0] cnt, cnt_nx;
  logic [4:0] shifted;
  logic [3:0] diff;
  logic       qbit;
  logic       start;
  logic       err;
  logic       unused_bits;

  assign start       = uio_in[0];
  assign unused_bits = &{1'b0, ena, uio_in[7:1]};

`ifdef DIVZERO_DETECT_EN
  logic err_nx;

  // error flag register, only present with zero-divisor detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_nx;
    end
  end
`else
  assign err = 1'b0;
`endif

  // next-state and datapath for one restoring step per CALC edge
  always_comb begin
    state_nx = state;
    dvd_nx   = dvd;
    dvs_nx   = dvs;
    rem_nx   = rem;
    quo_nx   = quo;
    q_nx     = q;
    r_nx     = r;
    cnt_nx   = cnt;
    qbit     = 1'b0;
`ifdef DIVZERO_DETECT_EN
    err_nx   = err;
`endif
    // the running remainder never exceeds 4 bits, so the shifted value fits in 5
    shifted  = {rem, dvd[3]};
    diff     = shifted[3:0] - dvs;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = CALC;
          dvd_nx   = ui_in[3:0];
          dvs_nx   = ui_in[7:4];
          rem_nx   = 4'd0;
          quo_nx   = 4'd0;
          cnt_nx   = 2'd0;
`ifdef DIVZERO_DETECT_EN
          err_nx   = 1'b0;
          if (ui_in[7:4] == 4'd0) begin
            state_nx = DONE;
            q_nx     = 4'hF;
            r_nx     = ui_in[3:0];
            err_nx   = 1'b1;
          end else begin
            err_nx   = 1'b0;
          end
`endif
        end else begin
          state_nx = state;
        end
      end
      CALC: begin
        dvd_nx = {dvd[2:0], 1'b0};
        if (shifted >= {1'b0, dvs}) begin
          rem_nx = diff;
          qbit   = 1'b1;
        end else begin
          rem_nx = shifted[3:0];
          qbit   = 1'b0;
        end
        quo_nx = {quo[2:0], qbit};
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nx = DONE;
          q_nx     = quo_nx;
          r_nx     = rem_nx;
        end else begin
          state_nx = CALC;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= 4'd0;
      dvs   <= 4'd0;
      rem   <= 4'd0;
      quo   <= 4'd0;
      q     <= 4'd0;
      r     <= 4'd0;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      dvd   <= dvd_nx;
      dvs   <= dvs_nx;
      rem   <= rem_nx;
      quo   <= quo_nx;
      q     <= q_nx;
      r     <= r_nx;
      cnt   <= cnt_nx;
    end
  end

  assign uo_out  = {r, q};
  assign uio_out = {4'b0000, err, (state == DONE), (state == CALC), 1'b0};
  assign uio_oe  = 8'b0000_1110;

endmodule

// File: doc/tt_um_seq_divider.md
TT_UM_SEQ_DIVIDER -- requirements
Module: tt_um_seq_divider

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: ena  input  1  design enable; ignored by logic.
REQ-004 SHALL have: ui_in  input  8  [3:0] dividend N, [7:4] divisor D, both unsigned.
REQ-005 SHALL have: uo_out  output  8  [3:0] quotient Q, [7:4] remainder R.
REQ-006 SHALL have: uio_in  input  8  [0] start; [7:1] ignored.
REQ-007 SHALL have: uio_out  output  8  [1] busy, [2] done, [3] err; [0],[7:4] driven 0.
REQ-008 SHALL have: uio_oe  output  8  constant 8'b0000_1110.
REQ-009 SHALL contain no parameters; operand width is fixed at 4 bits.

Function
REQ-010 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL latch N and D, clear the partial remainder, clear the 2-bit iteration counter, clear done and err, and enter CALC.
REQ-012 start SHALL be level-sampled; start=0 in IDLE/DONE SHALL hold state and outputs.
REQ-013 In CALC, each edge SHALL do one restoring step, MSB first: shift the next dividend bit into a 5-bit partial remainder, trial-subtract D, and keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-014 CALC SHALL last exactly 4 edges; on the 4th edge (counter=3) Q and R SHALL be written and the FSM SHALL enter DONE.
REQ-015 Latency: with start sampled at edge N, done SHALL be 1 after edge N+4.
REQ-016 busy SHALL be 1 exactly while in CALC; done SHALL be 1 exactly while in DONE.
REQ-017 uo_out SHALL change only on entry to DONE and SHALL hold until the next completion or reset.
REQ-018 start during CALC SHALL be ignored; operand changes on ui_in after latching SHALL not affect the result.
REQ-019 start=1 held continuously SHALL re-launch one edge after each DONE, giving a 5-cycle period.
REQ-020 Results SHALL satisfy N = Q*D + R with R < D for every D != 0.
REQ-021 D=0 without the feature in REQ-026 SHALL yield Q=4'hF and R=N after the normal 4 CALC edges, with err=0.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, Q=R=0, busy=done=err=0, and clear counter and partial remainder.
REQ-023 Reset SHALL take priority over start and over any CALC step.
REQ-024 Reset during CALC SHALL abort the operation with no done pulse.
REQ-025 uio_oe and the constant-0 uio_out bits SHALL be unaffected by reset.

Configuration
REQ-026 Macro DIVZERO_DETECT_EN defined: start with D=0 SHALL skip CALC, go IDLE/DONE->DONE in one edge with Q=4'hF, R=N, err=1, and busy never asserted.
REQ-027 DIVZERO_DETECT_EN undefined: no zero detection; uio_out[3] SHALL be tied to 0 and D=0 SHALL follow REQ-021.
REQ-028 The macro SHALL NOT change non-zero-divisor behaviour or latency.

Verification
REQ-029 N=13, D=3, start 1 cycle -> busy for 4 cycles, then done=1, uo_out=8'h14, err=0.
REQ-030 N=15, D=15 -> uo_out=8'h01; N=0, D=5 -> uo_out=8'h00; N=5, D=9 -> uo_out=8'h50.
REQ-031 N=7, D=0 -> with DIVZERO_DETECT_EN, done after 1 edge, uo_out=8'h7F, err=1; without it, done after 4 edges, uo_out=8'h7F, err=0.
REQ-032 Launch N=9, D=2, assert rst_n=0 on the 2nd CALC edge -> IDLE, uo_out=8'h00, no done; a relaunch then gives uo_out=8'h14.
REQ-033 Launch N=9, D=2, then pulse start with ui_in=8'h3F mid-CALC -> ignored, result uo_out=8'h14.
REQ-034 Exhaustive sweep of all 256 N/D pairs with start held high -> each result satisfies REQ-020/REQ-021 with a 5-cycle launch period.
